clk_div_prog: RTL and testbench

//  Multi-channel, runtime-programmable clock divider for the CHIP-8 core.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_chan.sv | 64 ++++++
 rtl/clk_div_prog.sv | 58 +++++
 tb/tb_clk_div_prog.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared helpers for the programmable clock divider: channel-select width,
// effective divisor (0 behaves as 1) and high-phase length at one extra bit.
package clk_div_pkg;

    localparam int MAX_W = 32;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_W-1:0] div_eff(input logic [MAX_W-1:0] d);
        return (d == '0) ? MAX_W'(1) : d;
    endfunction

    // One bit wider than the divisor so d = all-ones cannot overflow.
    function automatic logic [MAX_W:0] high_len(input logic [MAX_W-1:0] d);
        return ({1'b0, d} + (MAX_W+1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active divisor, shadow divisor and pending flag.
// Outputs decode registers only; a new divisor takes effect at the next wrap or restart.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] deff;
    logic             last;

    assign deff    = WIDTH'(div_eff(MAX_W'(div)));
    assign last    = (cnt == deff - WIDTH'(1));
    assign clk_out = ((MAX_W+1)'(cnt) < high_len(MAX_W'(deff)));
    assign tick    = run && last;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            div    <= WIDTH'(DEFAULT_DIV);
            shadow <= WIDTH'(DEFAULT_DIV);
            pend   <= 1'b0;
        end else begin
            if (restart) begin
                cnt <= '0;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
            end else if (run) begin
                if (last) begin
                    cnt <= '0;
                    if (pend) begin
                        div  <= shadow;
                        pend <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end
            // A write only lands when pend was clear, so it never overwrites
            // a value still waiting; it overrides the apply above by design.
            if (wr) begin
                shadow <= wr_div;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with valid/ready divisor reload.
// Optional per-channel run enable via `CLK_DIV_GATE_EN (default build: always running).
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int WIDTH       = 16,
    parameter  int DEFAULT_DIV = 1,
    localparam int CH_W        = ch_w(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              restart,
`ifdef CLK_DIV_GATE_EN
    input  logic [NUM_CH-1:0] ch_en,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0]    pend;
    logic [2**CH_W-1:0]   pend_all;
    logic                 accept;

    // Unused select codes read as never-pending, so writes to them are
    // accepted and silently dropped.
    assign pend_all  = (2**CH_W)'(pend);
    assign cfg_ready = !pend_all[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic run;
`ifdef CLK_DIV_GATE_EN
        assign run = ch_en[i];
`else
        assign run = 1'b1;
`endif
        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .rst     (rst),
            .run     (run),
            .restart (restart),
            .wr      (accept && (cfg_ch == CH_W'(i))),
            .wr_div  (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (NUM_CH=2, WIDTH=16, DEFAULT_DIV=1).
// Inputs are driven and outputs sampled on the falling edge.
module tb_clk_div_prog;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        restart;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
`ifdef CLK_DIV_GATE_EN
    logic [1:0]  ch_en;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    clk_div_prog #(
        .NUM_CH      (2),
        .WIDTH       (16),
        .DEFAULT_DIV (1)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .restart   (restart),
`ifdef CLK_DIV_GATE_EN
        .ch_en     (ch_en),
`endif
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic adv(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Write a divisor and restart so the channel starts a fresh period at cnt=0.
    task automatic set_div(input int ch, input int d);
        cfg_valid = 1'b1; cfg_ch = 1'(ch); cfg_div = 16'(d);
        adv(1);
        cfg_valid = 1'b0; restart = 1'b1;
        adv(1);
        restart = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        adv(2);
        checks++; if (clk_out !== 2'b11) begin errors++; $display("FAIL reset_clk got=%b exp=11", clk_out); end
        checks++; if (tick !== 2'b11) begin errors++; $display("FAIL reset_tick got=%b exp=11", tick); end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (clk_out !== 2'b11 || tick !== 2'b11) begin
                errors++; $display("FAIL div1_run k=%0d clk=%b tick=%b exp=11/11", k, clk_out, tick);
            end
            adv(1);
        end
    endtask

    task automatic test_div5;
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd5;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL div5_ready got=%b exp=1", cfg_ready); end
        adv(1);
        cfg_valid = 1'b0; restart = 1'b1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL div5_pend got=%b exp=0", cfg_ready); end
        adv(1);
        restart = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++; if (clk_out !== {1'b1, (k % 5) < 3} || tick !== {1'b1, (k % 5) == 4}) begin
                errors++; $display("FAIL div5 k=%0d clk=%b tick=%b exp_clk=%b exp_tick=%b",
                                   k, clk_out, tick, {1'b1, (k % 5) < 3}, {1'b1, (k % 5) == 4});
            end
            adv(1);
        end
    endtask

    task automatic test_reload;
        set_div(0, 4);
        adv(1);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd6;
        checks++; if (cfg_ready !== 1'b1 || clk_out[0] !== 1'b1) begin
            errors++; $display("FAIL reload_cnt1 ready=%b clk=%b exp=1/1", cfg_ready, clk_out[0]);
        end
        adv(1);
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0 || clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            errors++; $display("FAIL reload_cnt2 ready=%b clk=%b tick=%b exp=0/0/0", cfg_ready, clk_out[0], tick[0]);
        end
        adv(1);
        checks++; if (cfg_ready !== 1'b0 || tick[0] !== 1'b1) begin
            errors++; $display("FAIL reload_cnt3 ready=%b tick=%b exp=0/1", cfg_ready, tick[0]);
        end
        adv(1);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reload_applied ready=%b exp=1", cfg_ready); end
        for (int k = 0; k < 12; k++) begin
            checks++; if (clk_out[0] !== ((k % 6) < 3) || tick[0] !== ((k % 6) == 5)) begin
                errors++; $display("FAIL div6 k=%0d clk=%b tick=%b exp_clk=%b exp_tick=%b",
                                   k, clk_out[0], tick[0], (k % 6) < 3, (k % 6) == 5);
            end
            adv(1);
        end
    endtask

    task automatic test_zero;
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", cfg_ready); end
        adv(1);
        cfg_div = 16'd2;
        for (int i = 1; i <= 5; i++) begin
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL zero_stall i=%0d ready=%b exp=0", i, cfg_ready); end
            adv(1);
        end
        checks++; if (cfg_ready !== 1'b1 || tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
            errors++; $display("FAIL zero_applied ready=%b tick=%b clk=%b exp=1/1/1", cfg_ready, tick[0], clk_out[0]);
        end
        adv(1);
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0 || tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
            errors++; $display("FAIL zero_as_one ready=%b tick=%b clk=%b exp=0/1/1", cfg_ready, tick[0], clk_out[0]);
        end
        adv(1);
        checks++; if (clk_out[0] !== 1'b1 || tick[0] !== 1'b0) begin
            errors++; $display("FAIL div2_c0 clk=%b tick=%b exp=1/0", clk_out[0], tick[0]);
        end
        adv(1);
        checks++; if (clk_out[0] !== 1'b0 || tick[0] !== 1'b1) begin
            errors++; $display("FAIL div2_c1 clk=%b tick=%b exp=0/1", clk_out[0], tick[0]);
        end
        adv(1);
    endtask

    task automatic test_restart_write;
        logic ec1, et1;
        set_div(1, 5);
        adv(2);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd3; restart = 1'b1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rw_ready got=%b exp=1", cfg_ready); end
        adv(1);
        cfg_valid = 1'b0; restart = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rw_pend got=%b exp=0", cfg_ready); end
        for (int k = 0; k < 11; k++) begin
            if (k < 5) begin
                ec1 = (k < 3); et1 = (k == 4);
            end else begin
                ec1 = ((k - 5) % 3) < 2; et1 = ((k - 5) % 3) == 2;
            end
            checks++; if (clk_out !== {ec1, (k % 2) == 0} || tick !== {et1, (k % 2) == 1}) begin
                errors++; $display("FAIL restart_write k=%0d clk=%b tick=%b exp_clk=%b exp_tick=%b",
                                   k, clk_out, tick, {ec1, (k % 2) == 0}, {et1, (k % 2) == 1});
            end
            adv(1);
        end
    endtask

    task automatic test_async_reset;
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd7;
        adv(1);
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL arst_pend got=%b exp=0", cfg_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (clk_out !== 2'b11 || tick !== 2'b11 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL arst_now clk=%b tick=%b ready=%b exp=11/11/1", clk_out, tick, cfg_ready);
        end
        adv(1);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            adv(1);
            checks++; if (tick !== 2'b11 || clk_out !== 2'b11) begin
                errors++; $display("FAIL arst_after k=%0d clk=%b tick=%b exp=11/11", k, clk_out, tick);
            end
        end
    endtask

`ifdef CLK_DIV_GATE_EN
    task automatic test_gate;
        set_div(1, 5);
        adv(2);
        ch_en = 2'b01;
        for (int k = 0; k < 10; k++) begin
            adv(1);
            checks++; if (tick !== 2'b01 || clk_out !== 2'b11) begin
                errors++; $display("FAIL gate_frozen k=%0d clk=%b tick=%b exp=11/01", k, clk_out, tick);
            end
        end
        ch_en = 2'b11;
        adv(1);
        checks++; if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0) begin
            errors++; $display("FAIL gate_resume3 clk=%b tick=%b exp=0/0", clk_out[1], tick[1]);
        end
        adv(1);
        checks++; if (tick[1] !== 1'b1) begin errors++; $display("FAIL gate_resume4 tick=%b exp=1", tick[1]); end
        adv(1);
        #2 rst = 1'b1;
        #1;
        checks++; if (tick !== 2'b11 || clk_out !== 2'b11) begin
            errors++; $display("FAIL gate_arst clk=%b tick=%b exp=11/11", clk_out, tick);
        end
        adv(1);
        rst = 1'b0;
        adv(1);
    endtask
`endif

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = 16'd0; restart = 1'b0;
`ifdef CLK_DIV_GATE_EN
        ch_en = 2'b11;
`endif
        test_reset();
        test_div5();
        test_reload();
        test_zero();
        test_restart_write();
        test_async_reset();
`ifdef CLK_DIV_GATE_EN
        test_gate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
